tx_dmac_reader: RTL and testbench

AXI4 read-master DMA for the TX path. It fetches bursts from a DDR ring buffer filled by the host and streams the beats into the TX FIFO over AXI-Stream. The host credits data with fill ticks. The block tracks available bytes, wraps the address at the ring end, and reports bursts, underflows and bad responses.

---
 rtl/tx_dmac_reader.sv | 233 +++++++++++++++++++++++
 tb/tb_tx_dmac_reader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_dmac_reader.sv
// AXI4 read-master DMA: fetches credited bursts from a DDR ring and streams them to the TX FIFO.
// Optional TX_DMAC_TLAST_PER_BURST_EN marks the last beat of every burst with tlast.
module tx_dmac_reader #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_base_address,
  input  logic [CNT_W-1:0]  read_ddr_size,
  input  logic [8:0]        read_burst_len,
  input  logic [CNT_W-1:0]  read_burst_count,
  input  logic [16:0]       fill_bytes,
  input  logic              fill_tick,
  output logic              fill_tick_ack,
  input  logic              tx_fifo_has_space,
  output logic              read_busy,
  output logic [2:0]        read_state,
  output logic [8:0]        read_index,
  output logic [1:0]        read_rresp,
  output logic [CNT_W-1:0]  read_total_burst_count,
  output logic [CNT_W-1:0]  read_ddr_available,
  output logic              read_burst_tick,
  output logic [7:0]        read_underflow_count,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tx_tdata,
  output logic              m_axis_tx_tvalid,
  input  logic              m_axis_tx_tready,
  output logic              m_axis_tx_tlast
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;

  logic [2:0]        state_r;
  logic [2:0]        state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  avail_r;
  logic [CNT_W-1:0]  total_r;
  logic [8:0]        index_r;
  logic [1:0]        rresp_r;
  logic [7:0]        underflow_r;
  logic              ack_r;
  logic              arvalid_r;
  logic              tick_r;
  logic              stall_seen_r;

  logic [CNT_W-1:0]  burst_bytes_s;
  logic [ADDR_W-1:0] burst_bytes_a_s;
  logic [ADDR_W-1:0] size_a_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [ADDR_W-1:0] offset_next_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic [CNT_W+1:0]  fill_add_s;
  logic [CNT_W+1:0]  burst_sub_s;
  logic [CNT_W+1:0]  avail_sum_s;
  logic [CNT_W-1:0]  avail_next_s;
  logic [CNT_W-1:0]  total_inc_s;
  logic [8:0]        last_idx_s;
  logic              credit_s;
  logic              ar_hs_s;
  logic              r_hs_s;
  logic              last_beat_s;
  logic              run_done_s;
  logic              err_s;
  logic              can_issue_s;
  logic              unused_ok_s;

  assign burst_bytes_s   = {{(CNT_W-13){1'b0}}, read_burst_len, 4'b0000};
  assign burst_bytes_a_s = {{(ADDR_W-CNT_W){1'b0}}, burst_bytes_s};
  assign size_a_s        = {{(ADDR_W-CNT_W){1'b0}}, read_ddr_size};
  assign addr_inc_s      = addr_r + burst_bytes_a_s;
  assign offset_next_s   = addr_inc_s - read_base_address;
  assign addr_next_s     = (offset_next_s >= size_a_s) ? read_base_address : addr_inc_s;

  assign last_idx_s  = read_burst_len - 9'd1;
  assign credit_s    = fill_tick & ~ack_r;
  assign ar_hs_s     = arvalid_r & m_axi_arready;
  assign r_hs_s      = m_axi_rvalid & m_axi_rready;
  assign last_beat_s = r_hs_s & (index_r == last_idx_s);
  assign total_inc_s = total_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign run_done_s  = (read_burst_count != {CNT_W{1'b0}}) & (total_inc_s == read_burst_count);
  assign err_s       = rresp_r[1] | m_axi_rresp[1];
  assign can_issue_s = (avail_r >= burst_bytes_s) & tx_fifo_has_space;

  // Credit and AR handshake may land in the same cycle; both apply, then clamp to the ring size.
  assign fill_add_s   = credit_s ? {{(CNT_W-15){1'b0}}, fill_bytes} : {(CNT_W+2){1'b0}};
  assign burst_sub_s  = ar_hs_s ? {2'b00, burst_bytes_s} : {(CNT_W+2){1'b0}};
  assign avail_sum_s  = {2'b00, avail_r} + fill_add_s - burst_sub_s;
  assign avail_next_s = (avail_sum_s > {2'b00, read_ddr_size}) ? read_ddr_size : avail_sum_s[CNT_W-1:0];

  // rlast is deliberately ignored: the beat counter alone closes a burst.
  assign unused_ok_s = ^{m_axi_rlast, last_idx_s[8]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (read_enable) state_next_s = S_WAIT;
        else             state_next_s = S_IDLE;
      end
      S_WAIT: begin
        if (!read_enable)     state_next_s = S_IDLE;
        else if (can_issue_s) state_next_s = S_ADDR;
        else                  state_next_s = S_WAIT;
      end
      S_ADDR: begin
        if (ar_hs_s) state_next_s = S_DATA;
        else         state_next_s = S_ADDR;
      end
      S_DATA: begin
        if (last_beat_s && (run_done_s || err_s || !read_enable)) state_next_s = S_IDLE;
        else if (last_beat_s)                                     state_next_s = S_WAIT;
        else                                                      state_next_s = S_DATA;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Run counters, ring address, credit bookkeeping and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r       <= read_base_address;
      avail_r      <= {CNT_W{1'b0}};
      total_r      <= {CNT_W{1'b0}};
      index_r      <= 9'd0;
      rresp_r      <= 2'b00;
      underflow_r  <= 8'd0;
      ack_r        <= 1'b0;
      arvalid_r    <= 1'b0;
      tick_r       <= 1'b0;
      stall_seen_r <= 1'b0;
    end else begin
      avail_r <= avail_next_s;
      tick_r  <= last_beat_s;
      if (credit_s)        ack_r <= 1'b1;
      else if (!fill_tick) ack_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          addr_r       <= read_base_address;
          arvalid_r    <= 1'b0;
          stall_seen_r <= 1'b0;
          // Status stays readable in IDLE; counters clear only when a new run starts.
          if (read_enable) begin
            total_r <= {CNT_W{1'b0}};
            index_r <= 9'd0;
            rresp_r <= 2'b00;
          end
        end
        S_WAIT: begin
          if (read_enable && can_issue_s) begin
            arvalid_r    <= 1'b1;
            stall_seen_r <= 1'b0;
          end else if (read_enable) begin
            stall_seen_r <= 1'b1;
            if (!stall_seen_r && (avail_r < burst_bytes_s) && (total_r != {CNT_W{1'b0}}) &&
                (underflow_r != 8'hFF))
              underflow_r <= underflow_r + 8'd1;
          end
        end
        S_ADDR: begin
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            addr_r    <= addr_next_s;
          end
        end
        S_DATA: begin
          stall_seen_r <= 1'b0;
          if (r_hs_s) begin
            if (m_axi_rresp[1] && (m_axi_rresp > rresp_r)) rresp_r <= m_axi_rresp;
            if (index_r == last_idx_s) begin
              index_r <= 9'd0;
              total_r <= total_inc_s;
            end else begin
              index_r <= index_r + 9'd1;
            end
          end
        end
        default: begin
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output logic: zero-latency R-to-stream pass-through plus status.
  always_comb begin
    m_axi_rready     = (state_r == S_DATA) & m_axis_tx_tready;
    m_axis_tx_tvalid = (state_r == S_DATA) & m_axi_rvalid;
    m_axis_tx_tdata  = m_axi_rdata;
    read_busy        = (state_r != S_IDLE);
`ifdef TX_DMAC_TLAST_PER_BURST_EN
    m_axis_tx_tlast  = (state_r == S_DATA) & m_axi_rvalid & (index_r == last_idx_s);
`else
    m_axis_tx_tlast  = 1'b0;
`endif
  end

  assign read_state             = state_r;
  assign read_index             = index_r;
  assign read_rresp             = rresp_r;
  assign read_total_burst_count = total_r;
  assign read_ddr_available     = avail_r;
  assign read_burst_tick        = tick_r;
  assign read_underflow_count   = underflow_r;
  assign fill_tick_ack          = ack_r;
  assign m_axi_araddr           = addr_r;
  assign m_axi_arlen            = last_idx_s[7:0];
  assign m_axi_arvalid          = arvalid_r;

endmodule

// File: tb/tb_tx_dmac_reader.sv
// Directed self-checking bench for tx_dmac_reader with a small AXI read slave and stream sink.
module tb_tx_dmac_reader;
  localparam int ADDR_W = 48;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              read_enable;
  logic [ADDR_W-1:0] read_base_address;
  logic [CNT_W-1:0]  read_ddr_size;
  logic [8:0]        read_burst_len;
  logic [CNT_W-1:0]  read_burst_count;
  logic [16:0]       fill_bytes;
  logic              fill_tick;
  logic              fill_tick_ack;
  logic              tx_fifo_has_space;
  logic              read_busy;
  logic [2:0]        read_state;
  logic [8:0]        read_index;
  logic [1:0]        read_rresp;
  logic [CNT_W-1:0]  read_total_burst_count;
  logic [CNT_W-1:0]  read_ddr_available;
  logic              read_burst_tick;
  logic [7:0]        read_underflow_count;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [DATA_W-1:0] m_axis_tx_tdata;
  logic              m_axis_tx_tvalid;
  logic              m_axis_tx_tready;
  logic              m_axis_tx_tlast;

  tx_dmac_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .read_enable(read_enable),
    .read_base_address(read_base_address), .read_ddr_size(read_ddr_size),
    .read_burst_len(read_burst_len), .read_burst_count(read_burst_count),
    .fill_bytes(fill_bytes), .fill_tick(fill_tick), .fill_tick_ack(fill_tick_ack),
    .tx_fifo_has_space(tx_fifo_has_space), .read_busy(read_busy), .read_state(read_state),
    .read_index(read_index), .read_rresp(read_rresp),
    .read_total_burst_count(read_total_burst_count), .read_ddr_available(read_ddr_available),
    .read_burst_tick(read_burst_tick), .read_underflow_count(read_underflow_count),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tx_tdata(m_axis_tx_tdata), .m_axis_tx_tvalid(m_axis_tx_tvalid),
    .m_axis_tx_tready(m_axis_tx_tready), .m_axis_tx_tlast(m_axis_tx_tlast)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Slave/sink configuration written by the main sequence only.
  int err_beat      = -1;
  bit ar_ready_cfg  = 1'b1;
  bit tready_toggle = 1'b0;

  // Slave/sink state written by the responder process only.
  logic [ADDR_W-1:0] r_q[$];
  logic [ADDR_W-1:0] ar_log[$];
  logic [DATA_W-1:0] out_q[$];
  int beat_idx, beat_glob, mirror_err, data_cycles, tlast_cnt;

  // AXI read slave and stream sink: drive at negedge+2, sample handshakes at posedge-1.
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_tx_tready = 1'b0;
    beat_idx = 0; beat_glob = 0; mirror_err = 0; data_cycles = 0; tlast_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      m_axi_arready    = ar_ready_cfg;
      m_axis_tx_tready = tready_toggle ? ~m_axis_tx_tready : 1'b1;
      if (r_q.size() > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {16'h0000, r_q[0], 64'(beat_idx)};
        m_axi_rresp  = (beat_glob == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (beat_idx == int'(read_burst_len) - 1);
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = 1'b0;
      end
      #2;
      if (!rst_n) begin
        r_q.delete(); ar_log.delete(); out_q.delete();
        beat_idx = 0; beat_glob = 0; mirror_err = 0; data_cycles = 0; tlast_cnt = 0;
      end else begin
        if (m_axi_arvalid && m_axi_arready) begin
          r_q.push_back(m_axi_araddr);
          ar_log.push_back(m_axi_araddr);
        end
        if (read_state == 3'd3) begin
          data_cycles++;
          if (m_axi_rready !== m_axis_tx_tready || m_axis_tx_tvalid !== m_axi_rvalid) mirror_err++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          out_q.push_back(m_axis_tx_tdata);
          if (m_axis_tx_tlast) tlast_cnt++;
          beat_glob++;
          beat_idx++;
          if (beat_idx == int'(read_burst_len)) begin
            beat_idx = 0;
            void'(r_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; read_enable = 1'b0; fill_tick = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic credit(input int b);
    bit ok;
    @(negedge clk); #1;
    fill_bytes = 17'(b);
    fill_tick  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fill_tick_ack) begin ok = 1'b1; break; end
    end
    chk("credit_ack_rise", 64'(ok), 64'd1);
    #1 fill_tick = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!fill_tick_ack) begin ok = 1'b1; break; end
    end
    chk("credit_ack_fall", 64'(ok), 64'd1);
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (read_burst_tick) begin seen = 1'b1; break; end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int nb, input logic [47:0] a0,
                              input logic [47:0] a1);
    int errs;
    logic [DATA_W-1:0] exp;
    errs = 0;
    for (int i = 0; i < nb; i++) begin
      exp = {16'h0000, (i < 16) ? a0 : a1, 64'(i % 16)};
      if (i >= out_q.size()) errs++;
      else if (out_q[i] !== exp) errs++;
    end
    chk(tag, 64'(errs), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; read_enable = 1'b0; read_base_address = 48'h1000;
    read_ddr_size = 32'd4096; read_burst_len = 9'd16; read_burst_count = 32'd2;
    fill_bytes = 17'd0; fill_tick = 1'b0; tx_fifo_has_space = 1'b1;

    // Reset state
    do_reset();
    chk("rst_state", 64'(read_state), 64'd0);
    chk("rst_busy", 64'(read_busy), 64'd0);
    chk("rst_total", 64'(read_total_burst_count), 64'd0);
    chk("rst_avail", 64'(read_ddr_available), 64'd0);
    chk("rst_araddr", 64'(m_axi_araddr), 64'h1000);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_underflow", 64'(read_underflow_count), 64'd0);
    chk("rst_rresp", 64'(read_rresp), 64'd0);
    chk("rst_ack", 64'(fill_tick_ack), 64'd0);
    chk("rst_tick", 64'(read_burst_tick), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("arlen", 64'(m_axi_arlen), 64'd15);

    // Smoke: two bursts of 256 bytes
    credit(512);
    chk("smoke_avail_pre", 64'(read_ddr_available), 64'd512);
    #1 read_enable = 1'b1;
    wait_tick("smoke_tick1");
    wait_tick("smoke_tick2");
    chk("smoke_state_end", 64'(read_state), 64'd0);
    chk("smoke_total", 64'(read_total_burst_count), 64'd2);
    #1 read_enable = 1'b0;
    @(negedge clk);
    chk("smoke_idle_hold", 64'(read_state), 64'd0);
    chk("smoke_avail_end", 64'(read_ddr_available), 64'd0);
    chk("smoke_ar_count", 64'(ar_log.size()), 64'd2);
    chk("smoke_araddr0", 64'(ar_log[0]), 64'h1000);
    chk("smoke_araddr1", 64'(ar_log[1]), 64'h1100);
    chk("smoke_beats", 64'(out_q.size()), 64'd32);
    check_stream("smoke_data", 32, 48'h1000, 48'h1100);

    // Wrap: 512-byte ring, third burst returns to base; credit saturates at ring size
    do_reset();
    read_ddr_size = 32'd512; read_burst_count = 32'd3;
    credit(512);
    credit(256);
    chk("wrap_avail_sat", 64'(read_ddr_available), 64'd512);
    #1 read_enable = 1'b1;
    wait_tick("wrap_tick1");
    wait_tick("wrap_tick2");
    chk("wrap_state_wait", 64'(read_state), 64'd1);
    credit(256);
    wait_tick("wrap_tick3");
    chk("wrap_state_end", 64'(read_state), 64'd0);
    chk("wrap_total", 64'(read_total_burst_count), 64'd3);
    #1 read_enable = 1'b0;
    chk("wrap_araddr1", 64'(ar_log[1]), 64'h1100);
    chk("wrap_araddr2", 64'(ar_log[2]), 64'h1000);

    // Starved: second burst waits for more credit, one underflow event
    do_reset();
    read_ddr_size = 32'd4096; read_burst_count = 32'd2;
    credit(256);
    #1 read_enable = 1'b1;
    wait_tick("starve_tick1");
    chk("starve_state_wait", 64'(read_state), 64'd1);
    repeat (5) @(negedge clk);
    chk("starve_underflow", 64'(read_underflow_count), 64'd1);
    chk("starve_still_wait", 64'(read_state), 64'd1);
    credit(256);
    wait_tick("starve_tick2");
    chk("starve_state_end", 64'(read_state), 64'd0);
    chk("starve_total", 64'(read_total_burst_count), 64'd2);
    #1 read_enable = 1'b0;

    // Backpressure: tready toggles, rready must follow, beats in order
    do_reset();
    read_burst_count = 32'd1;
    tready_toggle = 1'b1;
    credit(256);
    #1 read_enable = 1'b1;
    wait_tick("bp_tick");
    chk("bp_state_end", 64'(read_state), 64'd0);
    #1 read_enable = 1'b0;
    tready_toggle = 1'b0;
    chk("bp_beats", 64'(out_q.size()), 64'd16);
    check_stream("bp_data", 16, 48'h1000, 48'h1100);
    chk("bp_mirror", 64'(mirror_err), 64'd0);
    chk("bp_stalled", 64'(data_cycles > 16), 64'd1);
`ifdef TX_DMAC_TLAST_PER_BURST_EN
    chk("bp_tlast", 64'(tlast_cnt), 64'd1);
`else
    chk("bp_tlast", 64'(tlast_cnt), 64'd0);
`endif

    // Error: SLVERR on beat 5 finishes the burst, then stops the run
    do_reset();
    read_burst_count = 32'd4;
    err_beat = 5;
    credit(512);
    #1 read_enable = 1'b1;
    wait_tick("err_tick");
    chk("err_state", 64'(read_state), 64'd0);
    chk("err_total", 64'(read_total_burst_count), 64'd1);
    chk("err_rresp", 64'(read_rresp), 64'h2);
    #1 read_enable = 1'b0;
    err_beat = -1;
    chk("err_beats", 64'(out_q.size()), 64'd16);
    chk("err_avail", 64'(read_ddr_available), 64'd256);

    // Collision: credit lands on the same edge as the AR handshake
    do_reset();
    read_burst_count = 32'd1;
    credit(256);
    ar_ready_cfg = 1'b0;
    #1 read_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axi_arvalid) begin seen = 1'b1; break; end
    end
    chk("coll_arvalid", 64'(seen), 64'd1);
    #1;
    ar_ready_cfg = 1'b1;
    fill_bytes = 17'd256;
    fill_tick = 1'b1;
    @(negedge clk);
    chk("coll_avail", 64'(read_ddr_available), 64'd256);
    chk("coll_ack", 64'(fill_tick_ack), 64'd1);
    chk("coll_state", 64'(read_state), 64'd3);
    #1 fill_tick = 1'b0;
    @(negedge clk);
    chk("coll_ack_fall", 64'(fill_tick_ack), 64'd0);
    wait_tick("coll_tick");
    chk("coll_total", 64'(read_total_burst_count), 64'd1);
    #1 read_enable = 1'b0;
    chk("coll_avail_end", 64'(read_ddr_available), 64'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
